// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register map,
// control bit positions, bus FSM states, reset values and byte-enable merge.
package timer_pkg;

    // Base of the timer window in the system address map, next to the UFM and RAM windows.
    localparam logic [31:0] TIMER_OFFSET = 32'h0000_3000;

    // Word index (addr[4:2]) of each timer register; indices 6 and 7 are unmapped.
    typedef enum logic [2:0] {
        TMR_CTRL        = 3'd0,
        TMR_MTIME_LO    = 3'd1,
        TMR_MTIME_HI    = 3'd2,
        TMR_MTIMECMP_LO = 3'd3,
        TMR_MTIMECMP_HI = 3'd4,
        TMR_PRESCALE    = 3'd5
    } reg_idx_e;

    // CTRL register bit positions.
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    // Bus responder states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RBURST  = 2'd1,
        ST_WACK    = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    // Register reset values.
    localparam logic [1:0]  CTRL_RST     = 2'b00;
    localparam logic [63:0] MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMECMP_RST = '1;
    localparam logic [15:0] PRESCALE_RST = 16'h0;

    // Replace the bytes of old_w selected by be with the matching bytes of new_w.
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_slave_if.sv
// Multicycle memory bus port between a master and the timer responder.
interface timer_slave_if #(
    parameter int ADDR_W  = 5,
    parameter int BURST_W = 4
);
    logic               chsel;
    logic               read;
    logic               write;
    logic [ADDR_W-1:0]  addr;
    logic [31:0]        wdata;
    logic [3:0]         dataena;
    logic [BURST_W-1:0] burstcount;
    logic [31:0]        rdata;
    logic               valid;
    logic               waitrequest;

    modport master (
        output chsel, read, write, addr, wdata, dataena, burstcount,
        input  rdata, valid, waitrequest
    );

    modport slave (
        input  chsel, read, write, addr, wdata, dataena, burstcount,
        output rdata, valid, waitrequest
    );
endinterface

// File: rtl/timer_core.sv
// Timer datapath: CTRL, PRESCALE, prescale counter, 64-bit mtime and mtimecmp,
// and the registered compare interrupt. Writes arrive one word at a time with byte enables.
module timer_core
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic [1:0]  ctrl,
    output logic [15:0] prescale,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        irq
);

    logic [1:0]  ctrl_q,     ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q,     pcnt_d;
    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] cmp_q,      cmp_d;
    logic        irq_q;

    logic        en;
    logic        tick;
    logic [31:0] ctrl_w, pre_w, lo_w, hi_w, cmp_lo_w, cmp_hi_w;

    assign en   = ctrl_q[CTRL_EN_BIT];
    assign tick = en && (pcnt_q == prescale_q);

    // Next-state for all timer registers: tick first, then a bus write overrides it.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        ctrl_w     = be_merge({30'd0, ctrl_q},     wr_data, wr_be);
        pre_w      = be_merge({16'd0, prescale_q}, wr_data, wr_be);
        lo_w       = be_merge(mtime_q[31:0],       wr_data, wr_be);
        hi_w       = be_merge(mtime_q[63:32],      wr_data, wr_be);
        cmp_lo_w   = be_merge(cmp_q[31:0],         wr_data, wr_be);
        cmp_hi_w   = be_merge(cmp_q[63:32],        wr_data, wr_be);
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        mtime_d    = mtime_q;
        cmp_d      = cmp_q;

        if (!en || tick) pcnt_d = '0;
        else             pcnt_d = pcnt_q + 16'd1;

        if (tick) mtime_d = mtime_q + 64'd1;

        // A write to either mtime half replaces the incremented value, so a
        // coincident tick is dropped rather than applied on top of the write.
        if (wr_en) begin
            case (wr_idx)
                TMR_CTRL: begin
                    ctrl_d = ctrl_w[1:0];
                    pcnt_d = '0;
                end
                TMR_MTIME_LO:    mtime_d = {mtime_q[63:32], lo_w};
                TMR_MTIME_HI:    mtime_d = {hi_w, mtime_q[31:0]};
                TMR_MTIMECMP_LO: cmp_d   = {cmp_q[63:32], cmp_lo_w};
                TMR_MTIMECMP_HI: cmp_d   = {cmp_hi_w, cmp_q[31:0]};
                TMR_PRESCALE: begin
                    prescale_d = pre_w[15:0];
                    pcnt_d     = '0;
                end
                default: ;
            endcase
        end
    end

    // Register update with synchronous reset; irq lags the compare by one cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            ctrl_q     <= CTRL_RST;
            prescale_q <= PRESCALE_RST;
            pcnt_q     <= '0;
            mtime_q    <= MTIME_RST;
            cmp_q      <= MTIMECMP_RST;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            irq_q      <= en && ctrl_q[CTRL_IRQ_EN_BIT] && (mtime_q >= cmp_q);
        end
    end

    assign ctrl     = ctrl_q;
    assign prescale = prescale_q;
    assign mtime    = mtime_q;
    assign mtimecmp = cmp_q;
    assign irq      = irq_q;

endmodule

// File: rtl/timer_slave.sv
// Bus responder for the machine timer: request decode, read-burst / write-ack FSM,
// registered read data and the mtime high-word shadow used for atomic 64-bit reads.
module timer_slave
    import timer_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int BURST_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    timer_slave_if.slave  bus,
    output logic          irq
);

    state_e             state_q, state_d;
    logic [2:0]         idx_q,   idx_d;
    logic [BURST_W-1:0] beats_q, beats_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic [31:0]        hi_shadow_q;

    logic [2:0]         req_idx;
    logic [2:0]         rd_sel;
    logic [31:0]        rd_word;
    logic               rd_fire;
    logic               core_wr;
    logic               addr_unused;

    logic [1:0]         ctrl;
    logic [15:0]        prescale;
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;

    assign req_idx     = bus.addr[4:2];
    assign addr_unused = ^bus.addr;

    timer_core u_core (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (core_wr),
        .wr_idx   (req_idx),
        .wr_data  (bus.wdata),
        .wr_be    (bus.dataena),
        .ctrl     (ctrl),
        .prescale (prescale),
        .mtime    (mtime),
        .mtimecmp (mtimecmp),
        .irq      (irq)
    );

    // The first beat reads the requested index; later beats walk the latched index.
    assign rd_sel = (state_q == ST_IDLE) ? req_idx : idx_q;

    // Read mux; MTIME_HI returns the shadow captured by the last MTIME_LO read.
    always_comb begin
        rd_word = '0;
        case (rd_sel)
            TMR_CTRL:        rd_word = {30'd0, ctrl};
            TMR_MTIME_LO:    rd_word = mtime[31:0];
            TMR_MTIME_HI:    rd_word = hi_shadow_q;
            TMR_MTIMECMP_LO: rd_word = mtimecmp[31:0];
            TMR_MTIMECMP_HI: rd_word = mtimecmp[63:32];
            TMR_PRESCALE:    rd_word = {16'd0, prescale};
            default:         rd_word = '0;
        endcase
    end

    // Bus FSM next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        valid_d = 1'b0;
        rdata_d = '0;
        rd_fire = 1'b0;
        core_wr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.chsel && bus.write) begin
                    core_wr = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_WACK;
                end else if (bus.chsel && bus.read) begin
                    rd_fire = 1'b1;
                    valid_d = 1'b1;
                    idx_d   = req_idx + 3'd1;
                    // beats_q counts the beats still to come after this one.
                    beats_d = (bus.burstcount == '0) ? '0 : bus.burstcount - BURST_W'(1);
                    state_d = ST_RBURST;
                end
            end
            ST_RBURST: begin
                if (beats_q == '0) begin
                    state_d = ST_RECOVER;
                end else begin
                    rd_fire = 1'b1;
                    valid_d = 1'b1;
                    idx_d   = idx_q + 3'd1;
                    beats_d = beats_q - BURST_W'(1);
                end
            end
            ST_WACK:    state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (rd_fire) rdata_d = rd_word;
    end

    // FSM, output and shadow registers; reset abandons any burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            beats_q     <= '0;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
            hi_shadow_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            if (rd_fire && rd_sel == TMR_MTIME_LO) hi_shadow_q <= mtime[63:32];
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.valid       = valid_q;
    assign bus.waitrequest = (state_q != ST_IDLE);

endmodule
